// File: rtl/watch_pkg.sv
// Shared constants and state encoding for the watch/timer datapath.
// The moduli are reused by the display mux and the dot-blink comparator.
package watch_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam int MSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    // Dot blink toggles at half a second.
    localparam int DOT_THRESHOLD = MSEC_MOD / 2;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

endpackage

// File: rtl/tick_gen.sv
// Clock divider: strobes `tick` combinationally during the last cycle of each
// CLK_FREQ/TICK_HZ period while enabled. The count freezes when disabled.
module tick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets its default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: run/stop/clear FSM, 100 Hz divider and the cascaded
// centisecond/second/minute/hour counters.
module stopwatch_counter
    import watch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int MSEC_MAX = watch_pkg::MSEC_MOD,
    parameter int SEC_MAX  = watch_pkg::SEC_MOD,
    parameter int MIN_MAX  = watch_pkg::MIN_MOD,
    parameter int HOUR_MAX = watch_pkg::HOUR_MOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_stop,
    input  logic              clear,
    output logic [MSEC_W-1:0] msec,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic              running,
    output logic              tick
);

    localparam logic [MSEC_W-1:0] MSEC_LAST = MSEC_W'(MSEC_MAX - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX - 1);
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX - 1);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

    state_e            state_q, state_d;
    logic [MSEC_W-1:0] msec_q, msec_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              running_q, running_d;
    logic              tick_q, tick_d;
    logic              div_tick;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == RUN),
        .clr  (state_q == CLEAR),
        .tick (div_tick)
    );

    // Clear has priority over run_stop; CLEAR itself ignores both inputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP: begin
                if (clear)         state_d = CLEAR;
                else if (run_stop) state_d = RUN;
            end
            RUN: begin
                if (clear)         state_d = CLEAR;
                else if (run_stop) state_d = STOP;
            end
            CLEAR:   state_d = STOP;
            default: state_d = STOP;
        endcase
        running_d = (state_d == RUN);
    end

    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        tick_d = div_tick;
        if (state_q == CLEAR) begin
            msec_d = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else if (div_tick) begin
            msec_d = (msec_q == MSEC_LAST) ? '0 : msec_q + 1'b1;
            if (msec_q == MSEC_LAST) begin
                sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + 1'b1;
                if (sec_q == SEC_LAST) begin
                    min_d = (min_q == MIN_LAST) ? '0 : min_q + 1'b1;
                    if (min_q == MIN_LAST) begin
                        hour_d = (hour_q == HOUR_LAST) ? '0 : hour_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STOP;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            msec_q    <= msec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            running_q <= running_d;
            tick_q    <= tick_d;
        end
    end

    assign msec    = msec_q;
    assign sec     = sec_q;
    assign min     = min_q;
    assign hour    = hour_q;
    assign running = running_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with a 10-cycle tick period and
// shortened sec/min/hour moduli so the full rollover is reachable quickly.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_stop;
    logic       clear;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       running;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_counter #(
        .CLK_FREQ (1000),
        .TICK_HZ  (100),
        .MSEC_MAX (100),
        .SEC_MAX  (6),
        .MIN_MAX  (2),
        .HOUR_MAX (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run_stop (run_stop),
        .clear    (clear),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .running  (running),
        .tick     (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int ms);
        check({tag, ".hour"}, 32'(hour), h);
        check({tag, ".min"},  32'(min),  m);
        check({tag, ".sec"},  32'(sec),  s);
        check({tag, ".msec"}, 32'(msec), ms);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_ticks(input int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
        end
    endtask

    task automatic pulse_run_stop();
        run_stop = 1'b1;
        cycles(1);
        run_stop = 1'b0;
    endtask

    initial begin
        int ticks;
        int first_tick;
        int last_tick;

        rst      = 1'b1;
        run_stop = 1'b0;
        clear    = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        check_time("reset", 0, 0, 0, 0);
        check("reset.running", 32'(running), 0);
        check("reset.tick", 32'(tick), 0);

        count_ticks(100, ticks);
        check("idle.ticks", ticks, 0);
        check_time("idle", 0, 0, 0, 0);
        check("idle.running", 32'(running), 0);

        // Start: tick every 10 cycles, first on the 10th edge after RUN entry.
        pulse_run_stop();
        check("run.running", 32'(running), 1);
        ticks      = 0;
        first_tick = 0;
        last_tick  = 0;
        for (int i = 1; i <= 999; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                if (ticks == 0) first_tick = i;
                last_tick = i;
                ticks++;
            end
        end
        check("run.ticks", ticks, 99);
        check("run.first_tick", first_tick, 10);
        check("run.last_tick", last_tick, 990);
        check_time("run999", 0, 0, 0, 99);
        cycles(1);
        check("carry.tick", 32'(tick), 1);
        check_time("carry", 0, 0, 1, 0);

        // Pause with the divider at 7, hold 50 cycles, resume.
        cycles(6);
        pulse_run_stop();
        check("pause.running", 32'(running), 0);
        count_ticks(50, ticks);
        check("pause.ticks", ticks, 0);
        check_time("pause", 0, 0, 1, 0);
        pulse_run_stop();
        check("resume.running", 32'(running), 1);
        check("resume.tick0", 32'(tick), 0);
        cycles(1);
        check("resume.tick1", 32'(tick), 0);
        cycles(1);
        check("resume.tick2", 32'(tick), 0);
        cycles(1);
        check("resume.tick3", 32'(tick), 1);
        check_time("resume", 0, 0, 1, 1);

        // 2297 more ticks reach 1:1:5.98 = one before the last code.
        cycles(22970);
        check_time("pre_roll", 1, 1, 5, 98);
        cycles(10);
        check_time("last", 1, 1, 5, 99);
        cycles(9);
        check("roll.no_early", 32'(tick), 0);
        check_time("roll_hold", 1, 1, 5, 99);
        cycles(1);
        check("roll.tick", 32'(tick), 1);
        check_time("rollover", 0, 0, 0, 0);

        // Simultaneous run_stop and clear: clear wins.
        cycles(5420);
        check_time("pre_clear", 0, 0, 5, 42);
        run_stop = 1'b1;
        clear    = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("clear.running", 32'(running), 0);
        check("clear.tick", 32'(tick), 0);
        cycles(1);
        run_stop = 1'b0;
        check_time("after_clear", 0, 0, 0, 0);
        check("after_clear.running", 32'(running), 0);
        count_ticks(20, ticks);
        check("after_clear.ticks", ticks, 0);
        check("after_clear.msec_hold", 32'(msec), 0);
        pulse_run_stop();
        cycles(9);
        check("div_restart.tick9", 32'(tick), 0);
        check("div_restart.msec9", 32'(msec), 0);
        cycles(1);
        check("div_restart.tick10", 32'(tick), 1);
        check("div_restart.msec10", 32'(msec), 1);

        // Reset asserted in the cycle where the divider is at its last count.
        cycles(9);
        check("pre_rst.tick", 32'(tick), 0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_time("rst_tick", 0, 0, 0, 0);
        check("rst_tick.running", 32'(running), 0);
        check("rst_tick.tick", 32'(tick), 0);
        count_ticks(30, ticks);
        check("rst_idle.ticks", ticks, 0);
        check("rst_idle.msec", 32'(msec), 0);
        pulse_run_stop();
        cycles(9);
        check("rst_div.tick9", 32'(tick), 0);
        cycles(1);
        check("rst_div.tick10", 32'(tick), 1);
        check("rst_div.msec", 32'(msec), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Upstream time-base stage of the blink watch/timer datapath.
- Divides the system clock to a 100 Hz tick and counts cascaded centiseconds/seconds/minutes/hours under run/stop/clear control.
- The `msec` output (0..99) feeds the dot-blink comparator directly; `sec`/`min`/`hour` feed the FND display mux.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- TICK_HZ, 100, count rate of the `msec` field; DIV = CLK_FREQ/TICK_HZ, must be an integer ≥ 2
- MSEC_MAX, 100, msec modulus
- SEC_MAX, 60, sec modulus
- MIN_MAX, 60, min modulus
- HOUR_MAX, 24, hour modulus

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- run_stop  input  1  single-cycle pulse (already debounced/edge-detected); toggles STOP<->RUN
- clear  input  1  single-cycle pulse; zeroes all counters
- msec  output  7  centiseconds, 0..99
- sec  output  6  seconds, 0..59
- min  output  6  minutes, 0..59
- hour  output  5  hours, 0..23
- running  output  1  high while in RUN
- tick  output  1  one-cycle 100 Hz strobe, gated by RUN (debug/chaining)

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high. No asynchronous logic.
- Reset (rst=1 at a rising edge):
  - state=STOP; msec=sec=min=hour=0; running=0; tick=0; divider count=0.
  - rst dominates every other input.
- FSM states:
  - STOP: hold all counters and the divider. run_stop -> RUN. clear -> CLEAR.
  - RUN: divider advances; counters update on tick. run_stop -> STOP. clear -> CLEAR.
  - CLEAR: one-cycle state. Zero all counters and the divider, then go to STOP unconditionally. Inputs are ignored in this cycle.
- Simultaneous run_stop and clear in one cycle: clear wins; run_stop is dropped.
- running is a registered output, equal to (state==RUN) from the cycle after the transition edge.
- Divider:
  - Counts 0..DIV-1 only in RUN.
  - tick=1 for exactly one cycle when the count equals DIV-1 in RUN; the count then wraps to 0.
  - On RUN->STOP the count is frozen, so pause/resume keeps the sub-tick phase.
  - The count is zeroed only by rst or CLEAR.
- Counter cascade, all updates registered in the tick cycle:
  - msec increments on tick and wraps 99->0.
  - sec increments on tick when msec==99; wraps 59->0.
  - min increments when msec==99 and sec==59; wraps 59->0.
  - hour increments when msec==99, sec==59 and min==59; wraps 23->0.
  - Full rollover 23:59:59.99 -> 00:00:00.00 occurs in a single edge.
- Latency: counter outputs change on the same edge tick is asserted.
- Counters never take values ≥ their modulus. Out-of-range values are unreachable from reset and need no recovery logic.
- A run_stop pulse arriving on the tick cycle in RUN: the increment is still applied, and state goes to STOP.

Decomposition:
- Shared package `watch_pkg`:
  - State encoding localparams: STOP=2'd0, RUN=2'd1, CLEAR=2'd2.
  - Moduli constants, reused by the display mux and the dot comparator threshold (MSEC_MAX/2).
- One sub-module, `tick_gen`:
  - Parameters CLK_FREQ, TICK_HZ.
  - Ports clk, rst, en, clr -> tick.
- Cascade counters and FSM stay in the top module.

Test Plan (CLK_FREQ=1000, TICK_HZ=100, so DIV=10):
- Reset then idle 100 cycles -> all outputs 0, running=0, no tick.
- run_stop pulse, run 1000 cycles -> running=1 one cycle after the pulse; tick every 10 cycles; msec=99, sec=0. One more tick -> msec=0, sec=1.
- Run 7 cycles into a tick period, pulse run_stop, wait 50 cycles, pulse run_stop again -> counters frozen during STOP; next tick arrives 3 cycles after resume.
- Force the count via run to 23:59:59.98 (or shorten with HOUR_MAX etc. overrides), then 2 ticks -> 23:59:59.99, then 00:00:00.00 in one edge.
- In RUN at 00:00:05.42, assert run_stop and clear together -> next cycle state CLEAR; following cycle STOP with all counters 0, running=0, divider restarts from 0.
- Assert rst mid-RUN on a tick cycle -> next cycle all outputs 0, state STOP, no increment applied.
